alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised successor to the single-cycle execute ALU: a WIDTH-bit ALU with a valid/ready handshake on input and output, a wider op set (xor, signed/unsigned compare, shifts), and an optional iterative unsigned multiply/divide unit. It sits in the execute stage of the RISC-V core. Single-cycle ops complete one cycle after acceptance. Mul/div ops stall the handshake for WIDTH cycles.

## Interface
- WIDTH, 32: operand and result width; must be a power of two and at least 8.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an op; high only in IDLE.
- SrcA, SrcB  in  WIDTH each  operands.
- ALUControl  in  4  op select (encoding below).
- out_valid  out  1  ALUResult/zero are valid.
- out_ready  in  1  consumer accepts the result.
- ALUResult  out  WIDTH  registered result.
- zero  out  1  ALUResult == 0, combinational from the registered result.
- busy  out  1  state != IDLE.

## Operation
- Op encoding:
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor.
  - 0101 slt (signed); 0110 sltu; 0111 sll; 1000 srl; 1001 sra.
  - 1010 mul (low WIDTH bits); 1011 mulhu (high WIDTH bits, unsigned).
  - 1100 divu; 1101 remu.
  - 1110, 1111 and any M op with the feature disabled: result 0.
- Shift amount is SrcB[log2(WIDTH)-1:0]; the upper bits are ignored.
- slt/sltu produce 1 or 0, zero-extended to WIDTH.
- add/sub wrap modulo 2^WIDTH; no overflow flag.
- FSM states: IDLE, ITER, DONE.
  - IDLE: on in_valid && in_ready, latch the op and operands.
    - Single-cycle op: compute into ALUResult, go to DONE.
    - mul/mulhu/divu/remu: load the iterator, go to ITER.
  - ITER: one step per cycle for WIDTH cycles (shift-add multiply; restoring divide). After the last step, write ALUResult and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE. Until then, hold ALUResult and out_valid.
- Division by zero: divu → all ones; remu → SrcA. No trap, same latency.
- Inputs are sampled only at acceptance. Changes on SrcA/SrcB/ALUControl afterwards have no effect.
- Reset, any state, including mid-iteration:
  - Next cycle: state=IDLE, out_valid=0, ALUResult=0, zero=1, busy=0, in_ready=1.
  - The partial result is discarded.

## Timing
- Acceptance at edge N. Single-cycle op: out_valid high from cycle N+1.
- Mul/div accepted at edge N: out_valid high from cycle N+WIDTH+1 (cycle 33 for WIDTH=32).
- in_ready is low from acceptance until the cycle after out_valid && out_ready. There is a minimum 1-cycle bubble between results; no back-to-back acceptance.
- out_valid && out_ready in DONE: out_valid drops and in_ready rises on the next cycle.
- out_ready while not in DONE is ignored.
- in_valid while in_ready=0 is ignored; no acceptance is recorded.

## Configuration
- ALU_MULDIV_EN defined:
  - Ops 1010–1101 use the iterative unit and ITER state.
- Undefined:
  - No iterator logic and no ITER state.
  - Ops 1010–1101 behave as single-cycle ops returning 0 (latency 1).

## Structure
- Shared package alu_pkg:
  - ALUControl op localparams.
  - FSM state enum (IDLE/ITER/DONE).
  - A helper function classifying an op as multi-cycle.
- Sub-module alu_iter_unit (instantiated only under ALU_MULDIV_EN):
  - Ports: start, op, operands, WIDTH-cycle counter, done pulse, result.
  - Holds the product/remainder registers and the step counter.
  - Cleared by reset.
- Top level holds the FSM, the combinational single-cycle datapath, the output register and the handshake.

## Test plan
- add 5+7, out_ready=1 → in_ready low one cycle; out_valid at N+1; ALUResult=12, zero=0. Then sub 9-9 → 0, zero=1.
- slt 0xFFFFFFFF,1 → 1; sltu same operands → 0; sra 0x80000000 by 0x24 (shift 4) → 0xF8000000.
- mul 0x00010000×0x00010000 → 0; mulhu same → 1; out_valid first high exactly 33 cycles after acceptance; in_ready low throughout.
- divu 100/7 → 14; remu → 2; divu 100/0 → 0xFFFFFFFF; remu 100/0 → 100.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → ALUResult and out_valid stable, in_ready=0, new in_valid ignored; raise out_ready → IDLE next cycle.
- Reset asserted at ITER cycle 10 of a divu → next cycle out_valid=0, ALUResult=0, zero=1, in_ready=1; a following add 1+1 returns 2 at latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute ALU.
//   - ALUControl op encodings (4 bits)
//   - FSM state type (IDLE / ITER / DONE)
//   - is_multicycle(): true for the ops handled by the iterative unit
//     (only meaningful when ALU_MULDIV_EN is defined)
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative unsigned multiply / divide unit, one step per clock for WIDTH steps.
// Only instantiated when ALU_MULDIV_EN is defined.
// Ports:
//   clk, reset      clock and synchronous active-high reset (clears all state)
//   start           load operands and op, begin iterating next cycle
//   op              OP_MUL / OP_MULHU / OP_DIVU / OP_REMU
//   src_a, src_b    multiplicand/multiplier or dividend/divisor
//   done            high during the cycle whose clock edge performs the last step
//   result          final result, valid while done is high
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic [CW-1:0]    count;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] upper_next;
  logic [WIDTH-1:0] lower_next;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic             is_div;

  assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);
  assign done   = running && (count == CW'(WIDTH - 1));

  // One iteration step. upper/lower act as {product_hi, product_lo} for the
  // shift-add multiply and as {remainder, quotient} for the restoring divide.
  // The divide needs no special case for a zero divisor: every compare
  // succeeds, so the quotient fills with ones and the remainder collects
  // the dividend bits unchanged.
  always_comb begin
    mul_sum    = {1'b0, upper} + (lower[0] ? {1'b0, opnd} : '0);
    div_shift  = {upper, lower[WIDTH-1]};
    div_ge     = (div_shift >= {1'b0, opnd});
    div_diff   = div_shift[WIDTH-1:0] - opnd;
    upper_next = mul_sum[WIDTH:1];
    lower_next = {mul_sum[0], lower[WIDTH-1:1]};
    if (is_div) begin
      upper_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lower_next = {lower[WIDTH-2:0], div_ge};
    end
  end

  // The result is taken from the step values so the top can register it on
  // the same edge as the final step.
  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:   result = lower_next;
      OP_MULHU: result = upper_next;
      OP_DIVU:  result = lower_next;
      OP_REMU:  result = upper_next;
      default:  result = '0;
    endcase
  end

  // Both ops load the first operand into the low half and the second into
  // opnd: the multiplier order does not matter, and the divider shifts the
  // dividend out of lower while dividing by opnd.
  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      count   <= '0;
      op_q    <= OP_ADD;
      upper   <= '0;
      lower   <= '0;
      opnd    <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      op_q    <= op;
      upper   <= '0;
      lower   <= src_a;
      opnd    <= src_b;
    end else if (running) begin
      upper <= upper_next;
      lower <= lower_next;
      count <= count + CW'(1);
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready handshakes on input and output.
// Single-cycle ops produce a result one cycle after acceptance; with the
// ALU_MULDIV_EN macro defined, mul/mulhu/divu/remu run through the iterative
// unit for WIDTH cycles, otherwise they return 0 with single-cycle latency.
// WIDTH must be a power of two and at least 8.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   SrcA, SrcB            operands
//   ALUControl            op select (see alu_pkg)
//   out_valid / out_ready result handshake
//   ALUResult             registered result
//   zero                  ALUResult == 0
//   busy                  FSM not in IDLE
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic             load_result;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] alu_out;
  logic [SHW-1:0]   shamt;

`ifdef ALU_MULDIV_EN
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;

  alu_iter_unit #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (iter_start),
    .op     (ALUControl),
    .src_a  (SrcA),
    .src_b  (SrcB),
    .done   (iter_done),
    .result (iter_result)
  );
`endif

  assign shamt     = SrcB[SHW-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign zero      = (ALUResult == '0);

  // Single-cycle datapath. It only matters in the acceptance cycle, so it
  // reads the ports directly instead of a latched copy.
  always_comb begin
    alu_out = '0;
    case (ALUControl)
      OP_ADD:  alu_out = SrcA + SrcB;
      OP_SUB:  alu_out = SrcA - SrcB;
      OP_AND:  alu_out = SrcA & SrcB;
      OP_OR:   alu_out = SrcA | SrcB;
      OP_XOR:  alu_out = SrcA ^ SrcB;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_SLL:  alu_out = SrcA << shamt;
      OP_SRL:  alu_out = SrcA >> shamt;
      OP_SRA:  alu_out = $unsigned($signed(SrcA) >>> shamt);
      default: alu_out = '0;
    endcase
  end

  // Next-state and result-load logic. DONE holds the result until the
  // consumer takes it; there is always one idle cycle between results.
  always_comb begin
    state_next  = state;
    load_result = 1'b0;
    result_next = alu_out;
`ifdef ALU_MULDIV_EN
    iter_start  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_MULDIV_EN
          if (is_multicycle(ALUControl)) begin
            iter_start = 1'b1;
            state_next = ITER;
          end else begin
            load_result = 1'b1;
            state_next  = DONE;
          end
`else
          load_result = 1'b1;
          state_next  = DONE;
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      ITER: begin
        if (iter_done) begin
          load_result = 1'b1;
          result_next = iter_result;
          state_next  = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ALUResult <= '0;
    end else begin
      state <= state_next;
      if (load_result) begin
        ALUResult <= result_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle. Expected results come from a
// hand-filled vector table and are queued at acceptance, then popped and
// compared when the result handshake completes. Expectations follow the
// build: with ALU_MULDIV_EN the M ops give real results after WIDTH+1
// cycles, otherwise 0 after one cycle.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int WIDTH = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD_ON  = 1'b1;
  localparam int MD_LAT = WIDTH + 1;
`else
  localparam bit MD_ON  = 1'b0;
  localparam int MD_LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             zero;
  logic             busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res_md;
    logic [WIDTH-1:0] res_off;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             z;
    int               lat;
    string            name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  alu_multicycle #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .zero       (zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic bit isMdOp(input logic [3:0] op);
    return (op >= 4'b1010) && (op <= 4'b1101);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic addVec(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] res_md, input logic [WIDTH-1:0] res_off);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res_md = res_md; v.res_off = res_off;
    vecs.push_back(v);
  endtask

  // Wait (bounded) for in_ready, present one op for exactly one edge, queue
  // its expectation, then scramble the inputs to show they are not re-read.
  task automatic applyStimulus(input string name, input logic [3:0] op,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] res, input int lat);
    exp_t e;
    int   guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s accept: in_ready stayed %0b, expected 1", name, in_ready);
      return;
    end
    in_valid   = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    @(posedge clk);
    e.res = res; e.z = (res == '0); e.lat = lat; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    in_valid   = 1'b0;
    SrcA       = $urandom;
    SrcB       = $urandom;
    ALUControl = 4'($urandom);
  endtask

  // Called on the negedge right after acceptance (latency 1 = that cycle).
  // Waits for out_valid, compares against the oldest queued expectation,
  // then completes the result handshake and checks the return to IDLE.
  task automatic checkOutput();
    exp_t e;
    int   lat = 1;
    bit   leak = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready || !busy) leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got output with empty queue, expected a pending op");
      return;
    end
    e = sb.pop_front();
    if (!out_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: out_valid=%0b after %0d cycles, expected 1", e.name, out_valid, lat);
      return;
    end
    check({e.name, " latency"}, 64'(lat), 64'(e.lat));
    check({e.name, " result"}, 64'(ALUResult), 64'(e.res));
    check({e.name, " zero"}, 64'(zero), 64'(e.z));
    check({e.name, " in_ready low while busy"}, 64'(leak | in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({e.name, " handshake {out_valid,in_ready}"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;

    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    SrcA       = '0;
    SrcB       = '0;
    ALUControl = '0;

    addVec(OP_ADD,   32'd5,        32'd7,        32'd12,       32'd12);
    addVec(OP_SUB,   32'd9,        32'd9,        32'd0,        32'd0);
    addVec(OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'hF000F000);
    addVec(OP_OR,    32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 32'h0F0F00F0);
    addVec(OP_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'hF0F00F0F);
    addVec(OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        32'd1);
    addVec(OP_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0);
    addVec(OP_SLT,   32'd1,        32'hFFFFFFFF, 32'd0,        32'd0);
    addVec(OP_SLTU,  32'd1,        32'hFFFFFFFF, 32'd1,        32'd1);
    addVec(OP_SLL,   32'd1,        32'h21,       32'd2,        32'd2);
    addVec(OP_SLL,   32'd3,        32'd31,       32'h80000000, 32'h80000000);
    addVec(OP_SRL,   32'h80000000, 32'h24,       32'h08000000, 32'h08000000);
    addVec(OP_SRA,   32'h80000000, 32'h24,       32'hF8000000, 32'hF8000000);
    addVec(OP_SRA,   32'h7FFFFFFF, 32'd31,       32'd0,        32'd0);
    addVec(OP_ADD,   32'hFFFFFFFF, 32'd1,        32'd0,        32'd0);
    addVec(OP_SUB,   32'd0,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF);
    addVec(4'b1110,  32'd5,        32'd7,        32'd0,        32'd0);
    addVec(4'b1111,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0);
    addVec(OP_MUL,   32'h00010000, 32'h00010000, 32'd0,        32'd0);
    addVec(OP_MULHU, 32'h00010000, 32'h00010000, 32'd1,        32'd0);
    addVec(OP_MUL,   32'd7,        32'd6,        32'd42,       32'd0);
    addVec(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0);
    addVec(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0);
    addVec(OP_DIVU,  32'd100,      32'd7,        32'd14,       32'd0);
    addVec(OP_REMU,  32'd100,      32'd7,        32'd2,        32'd0);
    addVec(OP_DIVU,  32'd100,      32'd0,        32'hFFFFFFFF, 32'd0);
    addVec(OP_REMU,  32'd100,      32'd0,        32'd100,      32'd0);
    addVec(OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'h19999999, 32'd0);
    addVec(OP_REMU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'd0);
    addVec(OP_DIVU,  32'd5,        32'd9,        32'd0,        32'd0);

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset ALUResult", 64'(ALUResult), 64'd0);
    check("reset zero", 64'(zero), 64'd1);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);

    // Table-driven vectors, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      logic [WIDTH-1:0] exp_res;
      int               exp_lat;
      exp_res = MD_ON ? vecs[i].res_md : vecs[i].res_off;
      exp_lat = (MD_ON && isMdOp(vecs[i].op)) ? MD_LAT : 1;
      applyStimulus($sformatf("vec%0d op=%b", i, vecs[i].op), vecs[i].op,
                    vecs[i].a, vecs[i].b, exp_res, exp_lat);
      checkOutput();
    end

    // Backpressure: result and flags hold in DONE, new requests are ignored
    out_ready = 1'b0;
    applyStimulus("bp add", OP_ADD, 32'd3, 32'd4, 32'd7, 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid   = 1'b1;
      ALUControl = OP_SUB;
      SrcA       = 32'd100;
      SrcB       = 32'd1;
      @(negedge clk);
      if (out_valid !== 1'b1 || ALUResult !== 32'd7 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    check("bp hold cycles bad", 64'(bad), 64'd0);
    checkOutput();
    @(negedge clk);
    check("bp no spurious accept", 64'({out_valid, busy}), 64'd0);

    // Reset during a divide: partial result discarded, nothing emerges later
    out_ready = 1'b0;
    applyStimulus("rst divu", OP_DIVU, 32'd100, 32'd7, 32'd14, MD_LAT);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset ALUResult", 64'(ALUResult), 64'd0);
    check("midreset zero", 64'(zero), 64'd1);
    check("midreset in_ready", 64'(in_ready), 64'd1);
    check("midreset busy", 64'(busy), 64'd0);
    reset = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("midreset stays idle", 64'(bad), 64'd0);
    applyStimulus("post-reset add", OP_ADD, 32'd1, 32'd1, 32'd2, 1);
    checkOutput();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
